// File: rtl/req_ack_pkg.sv
// Shared definitions for the req/ack responder: parameter limits, the
// in-flight counter width calculation and the saturating-counter helper.
package req_ack_pkg;

    localparam int MIN_CHANNELS = 1;
    localparam int MIN_LATENCY  = 1;
    localparam int MIN_SPACING  = 1;
    localparam int MIN_CNT_W    = 2;
    localparam int MAX_CNT_W    = 31;

    // Width that holds 0..latency, the worst-case in-flight count.
    function automatic int out_width(input int latency);
        return $clog2(latency + 1);
    endfunction

    // True while a counter of the given width can still advance without wrapping.
    function automatic logic sat_room(input logic [31:0] value, input int width);
        return value < ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic params_ok(input int channels, input int latency,
                                       input int min_gap, input int cnt_w);
        return (channels >= MIN_CHANNELS) && (latency >= MIN_LATENCY) &&
               (min_gap >= MIN_SPACING) && (cnt_w >= MIN_CNT_W) && (cnt_w <= MAX_CNT_W);
    endfunction

endpackage

// File: rtl/req_ack_chan.sv
// One responder channel: gap timer, ack delay line, in-flight count, event counters, err.
// Embedded properties are compiled only with REQ_ACK_RESPONDER_ASSERT_EN defined.
module req_ack_chan
    import req_ack_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int MIN_GAP = 8,
    parameter int CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req,
    input  logic                             clr_err,
    output logic                             ack,
    output logic                             drop,
    output logic                             err,
    output logic                             busy,
    output logic [out_width(LATENCY)-1:0]    outstanding,
    output logic [CNT_W-1:0]                 req_cnt,
    output logic [CNT_W-1:0]                 ack_cnt
);

    localparam int OUT_W = out_width(LATENCY);
    localparam int TMR_W = $clog2(MIN_GAP + 1);
    localparam logic [TMR_W-1:0] GAP_READY = TMR_W'(MIN_GAP);

    logic [TMR_W-1:0]   gap_tmr;
    logic [LATENCY-1:0] line;
    logic [OUT_W-1:0]   out_nxt;
    logic               ready;
    logic               accept;
    logic               reject;

    assign ready  = (gap_tmr == GAP_READY);
    assign accept = req && ready;
    assign reject = req && !ready;
    // The last stage of the line is itself the ack flop.
    assign ack    = line[LATENCY-1];

    // A rejected req leaves the timer running, so spacing is measured from the last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_tmr <= GAP_READY;
            line    <= '0;
        end else begin
            if (accept) begin
                gap_tmr <= TMR_W'(1);
            end else if (!ready) begin
                gap_tmr <= gap_tmr + TMR_W'(1);
            end else begin
                gap_tmr <= gap_tmr;
            end
            line <= (line << 1) | LATENCY'(accept);
        end
    end

    always_comb begin
        out_nxt = outstanding;
        case ({accept, ack})
            2'b10:   out_nxt = outstanding + OUT_W'(1);
            2'b01:   out_nxt = outstanding - OUT_W'(1);
            default: out_nxt = outstanding;
        endcase
    end

    // Status and saturating event counters; err keeps priority of a new drop over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            busy        <= 1'b0;
            drop        <= 1'b0;
            err         <= 1'b0;
            req_cnt     <= '0;
            ack_cnt     <= '0;
        end else begin
            outstanding <= out_nxt;
            busy        <= (out_nxt != '0);
            drop        <= reject;
            if (reject) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end else begin
                err <= err;
            end
            if (accept && sat_room(32'(req_cnt), CNT_W)) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end else begin
                req_cnt <= req_cnt;
            end
            if (ack && sat_room(32'(ack_cnt), CNT_W)) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end else begin
                ack_cnt <= ack_cnt;
            end
        end
    end

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
    localparam int OUT_MAX = (LATENCY + MIN_GAP - 1) / MIN_GAP;

    int unsigned since_acc;

    // Independent spacing reference, measured from the last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            since_acc <= MIN_GAP;
        end else if (accept) begin
            since_acc <= 1;
        end else if (since_acc < MIN_GAP) begin
            since_acc <= since_acc + 1;
        end else begin
            since_acc <= since_acc;
        end
    end

    a_ack_latency: assert property (@(posedge clk) disable iff (rst)
        ack |-> $past(accept, LATENCY));
    a_min_gap: assert property (@(posedge clk) disable iff (rst)
        accept |-> (since_acc >= MIN_GAP));
    a_out_bound: assert property (@(posedge clk) disable iff (rst)
        int'(outstanding) <= OUT_MAX);
    a_cnt_order: assert property (@(posedge clk) disable iff (rst)
        (ack_cnt <= req_cnt) || (req_cnt == {CNT_W{1'b1}}));
    c_overlap: cover property (@(posedge clk) disable iff (rst) outstanding >= OUT_W'(2));
    c_drop: cover property (@(posedge clk) disable iff (rst) drop);
`endif

endmodule

// File: rtl/req_ack_responder.sv
// Multi-channel req/ack responder: CHANNELS independent req_ack_chan instances with
// packed status ports. REQ_ACK_RESPONDER_ASSERT_EN enables the embedded properties.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 4,
    parameter int MIN_GAP  = 8,
    parameter int CNT_W    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [CHANNELS-1:0]                      req,
    input  logic                                     clr_err,
    output logic [CHANNELS-1:0]                      ack,
    output logic [CHANNELS-1:0]                      drop,
    output logic [CHANNELS-1:0]                      err,
    output logic [CHANNELS-1:0]                      busy,
    output logic [CHANNELS*out_width(LATENCY)-1:0]   outstanding,
    output logic [CHANNELS*CNT_W-1:0]                req_cnt,
    output logic [CHANNELS*CNT_W-1:0]                ack_cnt
);

    localparam int OUT_W = out_width(LATENCY);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        req_ack_chan #(
            .LATENCY (LATENCY),
            .MIN_GAP (MIN_GAP),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .req         (req[g]),
            .clr_err     (clr_err),
            .ack         (ack[g]),
            .drop        (drop[g]),
            .err         (err[g]),
            .busy        (busy[g]),
            .outstanding (outstanding[g*OUT_W +: OUT_W]),
            .req_cnt     (req_cnt[g*CNT_W +: CNT_W]),
            .ack_cnt     (ack_cnt[g*CNT_W +: CNT_W])
        );
    end

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
    a_params: assert property (@(posedge clk) disable iff (rst)
        params_ok(CHANNELS, LATENCY, MIN_GAP, CNT_W));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder: three instances (default, MIN_GAP=1, CNT_W=2)
// share clk/rst/clr_err; expected acks and drops are queued when reqs are driven.
module tb_req_ack_responder;

    localparam int NI  = 3;
    localparam int NC  = 4;
    localparam int LAT = 4;
    localparam int OW  = 3;
    localparam int GAP  [NI] = '{8, 1, 8};
    localparam int CMAX [NI] = '{255, 255, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          clr_err = 1'b0;
    logic [NC-1:0] req0 = '0, req1 = '0, req2 = '0;
    logic [NC-1:0] ack0, ack1, ack2, drop0, drop1, drop2;
    logic [NC-1:0] err0, err1, err2, busy0, busy1, busy2;
    logic [NC*OW-1:0] out0, out1, out2;
    logic [NC*8-1:0]  rc0, ac0, rc1, ac1;
    logic [NC*2-1:0]  rc2, ac2;

    req_ack_responder #(.CHANNELS(4), .LATENCY(4), .MIN_GAP(8), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .clr_err(clr_err), .ack(ack0), .drop(drop0),
        .err(err0), .busy(busy0), .outstanding(out0), .req_cnt(rc0), .ack_cnt(ac0));
    req_ack_responder #(.CHANNELS(4), .LATENCY(4), .MIN_GAP(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .clr_err(clr_err), .ack(ack1), .drop(drop1),
        .err(err1), .busy(busy1), .outstanding(out1), .req_cnt(rc1), .ack_cnt(ac1));
    req_ack_responder #(.CHANNELS(4), .LATENCY(4), .MIN_GAP(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .clr_err(clr_err), .ack(ack2), .drop(drop2),
        .err(err2), .busy(busy2), .outstanding(out2), .req_cnt(rc2), .ack_cnt(ac2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    int ackq  [NI][NC][$];
    int dropq [NI][NC][$];
    int last_acc [NI][NC];
    int e_req [NI][NC];
    int e_ack [NI][NC];
    int e_err [NI][NC];

    int o_ack [NI][NC], o_drop [NI][NC], o_err [NI][NC], o_busy [NI][NC];
    int o_out [NI][NC], o_rc [NI][NC], o_ac [NI][NC];

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            o_ack[0][c] = int'(ack0[c]);  o_ack[1][c] = int'(ack1[c]);  o_ack[2][c] = int'(ack2[c]);
            o_drop[0][c] = int'(drop0[c]); o_drop[1][c] = int'(drop1[c]); o_drop[2][c] = int'(drop2[c]);
            o_err[0][c] = int'(err0[c]);  o_err[1][c] = int'(err1[c]);  o_err[2][c] = int'(err2[c]);
            o_busy[0][c] = int'(busy0[c]); o_busy[1][c] = int'(busy1[c]); o_busy[2][c] = int'(busy2[c]);
            o_out[0][c] = int'(out0[c*OW +: OW]);
            o_out[1][c] = int'(out1[c*OW +: OW]);
            o_out[2][c] = int'(out2[c*OW +: OW]);
            o_rc[0][c] = int'(rc0[c*8 +: 8]); o_ac[0][c] = int'(ac0[c*8 +: 8]);
            o_rc[1][c] = int'(rc1[c*8 +: 8]); o_ac[1][c] = int'(ac1[c*8 +: 8]);
            o_rc[2][c] = int'(rc2[c*2 +: 2]); o_ac[2][c] = int'(ac2[c*2 +: 2]);
        end
    end

    task automatic check_val(input string tag, input int k, input int c, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s inst%0d ch%0d cycle %0d: got %0d expected %0d", tag, k, c, cyc, got, exp);
        end
    endtask

    // Compare every output against the scoreboard once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < NC; c++) begin
                    bit ack_due;
                    bit drop_due;
                    ack_due  = (ackq[k][c].size() > 0) && (ackq[k][c][0] == cyc);
                    drop_due = (dropq[k][c].size() > 0) && (dropq[k][c][0] == cyc);
                    check_val("ack", k, c, o_ack[k][c], int'(ack_due));
                    check_val("drop", k, c, o_drop[k][c], int'(drop_due));
                    check_val("outstanding", k, c, o_out[k][c], ackq[k][c].size());
                    check_val("busy", k, c, o_busy[k][c], int'(ackq[k][c].size() != 0));
                    check_val("err", k, c, o_err[k][c], e_err[k][c]);
                    check_val("req_cnt", k, c, o_rc[k][c], e_req[k][c]);
                    check_val("ack_cnt", k, c, o_ac[k][c], e_ack[k][c]);
                    if (ack_due) begin
                        void'(ackq[k][c].pop_front());
                        if (e_ack[k][c] < CMAX[k]) e_ack[k][c]++;
                    end
                    if (drop_due) void'(dropq[k][c].pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs and record what the coming edge should do.
    task automatic drive(input logic [NC-1:0] r0, input logic [NC-1:0] r1,
                         input logic [NC-1:0] r2, input logic clr, input logic rs);
        logic [NC-1:0] r [NI];
        int e;
        r[0] = r0; r[1] = r1; r[2] = r2;
        e = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (rs) begin
                    ackq[k][c].delete();
                    dropq[k][c].delete();
                    last_acc[k][c] = -1000;
                    e_req[k][c] = 0;
                    e_ack[k][c] = 0;
                    e_err[k][c] = 0;
                end else begin
                    if (clr) e_err[k][c] = 0;
                    if (r[k][c]) begin
                        if (e - last_acc[k][c] >= GAP[k]) begin
                            last_acc[k][c] = e;
                            ackq[k][c].push_back(e + LAT - 1);
                            if (e_req[k][c] < CMAX[k]) e_req[k][c]++;
                        end else begin
                            dropq[k][c].push_back(e);
                            e_err[k][c] = 1;
                        end
                    end
                end
            end
        end
        req0 = r0; req1 = r1; req2 = r2;
        clr_err = clr;
        rst = rs;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        drive('0, '0, '0, 1'b0, 1'b1);
        mon_en = 1'b1;
        drive('0, '0, '0, 1'b0, 1'b1);
        idle(3);
        // single req, then a spacing violation followed by a legal req and an err clear
        drive(4'b0001, '0, '0, 1'b0, 1'b0);
        idle(12);
        drive(4'b0010, '0, '0, 1'b0, 1'b0);
        idle(3);
        drive(4'b0010, '0, '0, 1'b0, 1'b0);
        idle(3);
        drive(4'b0010, '0, '0, 1'b0, 1'b0);
        idle(2);
        drive('0, '0, '0, 1'b1, 1'b0);
        idle(10);
        // drop coinciding with clr_err keeps err set
        drive(4'b0010, '0, '0, 1'b0, 1'b0);
        drive(4'b0010, '0, '0, 1'b0, 1'b0);
        drive(4'b0010, '0, '0, 1'b1, 1'b0);
        idle(2);
        drive('0, '0, '0, 1'b1, 1'b0);
        idle(8);
        // back-to-back accepts with MIN_GAP=1, then all channels at once
        drive('0, 4'b0100, '0, 1'b0, 1'b0);
        drive('0, 4'b0100, '0, 1'b0, 1'b0);
        drive('0, 4'b0100, '0, 1'b0, 1'b0);
        idle(8);
        drive(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0);
        idle(10);
        // reset in flight cancels the pending ack; timer ready right after
        drive(4'b0001, '0, '0, 1'b0, 1'b0);
        idle(1);
        drive('0, '0, '0, 1'b0, 1'b1);
        drive(4'b0001, '0, '0, 1'b0, 1'b0);
        idle(10);
        // counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            drive('0, '0, 4'b1000, 1'b0, 1'b0);
            idle(7);
        end
        idle(6);
        // mixed random traffic
        for (int i = 0; i < 150; i++) begin
            logic [NC-1:0] ra;
            logic [NC-1:0] rb;
            logic [NC-1:0] rc;
            for (int b = 0; b < NC; b++) begin
                ra[b] = ($urandom_range(0, 3) == 0);
                rc[b] = ($urandom_range(0, 5) == 0);
            end
            rb = NC'($urandom_range(0, 15));
            drive(ra, rb, rc, ($urandom_range(0, 9) == 0), 1'b0);
        end
        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
